sa_sched: RTL and testbench
===========================

# sa_sched

Job sequencer for the 16x16 systolic array output wrapper (`SA_out`). Given a `start` request, it streams one 16-row tile from the input data/weight buffers into the array, asserts `SA_fire_in` in step with the data, and holds the enabled output-memory banks selected through `CEN`. It then waits for the array to drain, using `SA_fire_out`, and signals completion or timeout to the host-side controller.

## Interface
- `TIMEOUT`, 255: maximum number of WAIT_OUT cycles before the job is aborted with an error.
- `DRAIN_CYCLES`, 2: cycles held after the last `SA_fire_out` so the negedge result register and memory write can complete.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: job request; sampled only in IDLE.
- `abort` in 1: synchronous cancel; any state returns to IDLE on the next edge.
- `bank_en` in 16: per-bank enable for output memory; captured on an accepted `start`.
- `in_rd_en` out 1: read strobe to the data/weight buffers, which have 1-cycle read latency.
- `in_rd_addr` out 4: row index 0..15.
- `SA_fire_in` out 1: fire to the array; `in_rd_en` delayed by one cycle.
- `SA_fire_out` in 1: fire propagated out of the array.
- `CEN` out 16: active-low bank enables to `SA_out`.
- `busy` out 1: high whenever state is not IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: timeout flag; valid while `done` is high and held until the next accepted `start`.

## Operation
- States and transitions:
  - IDLE -> LOAD when `start`=1.
  - LOAD lasts exactly 16 cycles, then goes to WAIT_OUT.
  - WAIT_OUT -> DRAIN when the fire-out count reaches 16.
  - WAIT_OUT -> DONE with `err`=1 when the timeout counter reaches `TIMEOUT`.
  - DRAIN lasts `DRAIN_CYCLES` cycles, then goes to DONE.
  - DONE lasts 1 cycle, then goes to IDLE.
- LOAD: `in_rd_en`=1; `in_rd_addr` counts 0..15, with no wrap beyond one pass.
- WAIT_OUT:
  - A 5-bit counter counts the cycles in which `SA_fire_out`=1.
  - Fire-out cycles need not be contiguous.
  - The timeout counter is `$clog2(TIMEOUT+1)` bits and increments every WAIT_OUT cycle.
- CEN:
  - `CEN = ~bank_en_q` in LOAD, WAIT_OUT and DRAIN.
  - `CEN` = 16'hFFFF in IDLE and DONE.
  - If `bank_en` is all zero, the job still runs and `CEN` stays all ones.
- `start` in any state other than IDLE is ignored; requests are not queued.
- `abort`:
  - Takes priority over every other transition.
  - Next cycle: IDLE, all counters cleared, `CEN` all ones, `in_rd_en`=0, `SA_fire_in`=0.
  - No `done` pulse is produced and `err` is unchanged.
- `start` and `abort` asserted together in IDLE: `abort` wins and no job starts.
- `SA_fire_out` seen in IDLE or LOAD is ignored and not counted.
- Reset values: state=IDLE, `in_rd_en`=0, `in_rd_addr`=0, `SA_fire_in`=0, `CEN`=16'hFFFF, `busy`=0, `done`=0, `err`=0, `bank_en_q`=0.
- A reset during a job behaves like `abort`, except that `err` is also cleared.

## Timing
- `start` sampled at edge t:
  - LOAD covers cycles t+1..t+16, with `in_rd_addr` = k-1 in cycle t+k.
  - `SA_fire_in` is high during t+2..t+17.
- WAIT_OUT begins at t+17.
- The 16th fire-out cycle observed at cycle w gives DRAIN at w+1..w+`DRAIN_CYCLES`, then `done` at w+`DRAIN_CYCLES`+1.
- Timeout: `done` with `err` is asserted in the cycle after `TIMEOUT` WAIT_OUT cycles.
- Back-to-back jobs: a `start` in the IDLE cycle immediately after DONE is accepted, giving a minimum job period of 16 + 16 + `DRAIN_CYCLES` + 2 cycles.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- `sa_pkg` holds:
  - `SA_DIM`=16 and `SA_ADDR_W`=4.
  - The state enum `sa_sched_state_t` (IDLE, LOAD, WAIT_OUT, DRAIN, DONE).
- The block is a single module with no sub-modules; the counters live inline.
- The block is instantiated alongside `SA_out`: `CEN` and `SA_fire_in` connect directly to it, and `SA_fire_out` is fed back.

## Test plan
- Nominal job: `bank_en`=16'hFFFF, `start` at t, `SA_fire_out` high for 16 cycles starting at t+20 -> `in_rd_addr` 0..15 at t+1..t+16, `SA_fire_in` high t+2..t+17, `CEN`=0 from t+1 to t+37, `done` at t+38, `err`=0.
- Bank mask: `bank_en`=16'h00F0 -> `CEN`=16'hFF0F during the job and 16'hFFFF at IDLE and DONE.
- Timeout: `TIMEOUT`=8, `SA_fire_out` never asserted -> `done` with `err`=1 at t+25, `err` held through IDLE, cleared on the next `start`.
- Gapped fire-out: 16 high cycles with 1-cycle gaps -> DRAIN entered only after the 16th high cycle; a `start` pulsed during WAIT_OUT is ignored.
- Abort in LOAD at t+5 -> at t+6 state=IDLE, `in_rd_en`=0, `CEN`=16'hFFFF, no `done`; a new `start` at t+7 runs normally.
- Reset mid-WAIT_OUT with `err` previously 1 -> all outputs return to reset values immediately (asynchronously), `err`=0.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared constants and state encoding for the systolic-array job sequencer.
package sa_pkg;
  localparam int SA_DIM    = 16;
  localparam int SA_ADDR_W = 4;

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_OUT, DRAIN, DONE} sa_sched_state_t;
endpackage

// File: rtl/sa_sched.sv
// Streams one 16-row tile into the systolic array, waits for SA_fire_out to drain,
// then reports done/err to the host controller. All outputs come from flops.
module sa_sched import sa_pkg::*; #(
  parameter int TIMEOUT      = 255,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [SA_DIM-1:0]    bank_en,
  output logic                 in_rd_en,
  output logic [SA_ADDR_W-1:0] in_rd_addr,
  output logic                 SA_fire_in,
  input  logic                 SA_fire_out,
  output logic [SA_DIM-1:0]    CEN,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam int DR_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [TO_W-1:0]      TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [DR_W-1:0]      DR_LAST   = DR_W'(DRAIN_CYCLES - 1);
  localparam logic [SA_ADDR_W-1:0] ADDR_LAST = SA_ADDR_W'(SA_DIM - 1);
  localparam logic [4:0]           FIRE_LAST = 5'(SA_DIM - 1);

  sa_sched_state_t   state;
  logic [SA_DIM-1:0] bank_en_q;
  logic              cen_on;
  logic [4:0]        fire_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [DR_W-1:0]   dr_cnt;

  // cen_on is the registered "job owns the banks" flag; the mask itself is held in bank_en_q.
  assign CEN = cen_on ? ~bank_en_q : '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bank_en_q  <= '0;
      cen_on     <= 1'b0;
      in_rd_en   <= 1'b0;
      in_rd_addr <= '0;
      SA_fire_in <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      fire_cnt   <= '0;
      to_cnt     <= '0;
      dr_cnt     <= '0;
    end else if (abort) begin
      // err deliberately left alone so the host can still read the last job's status.
      state      <= IDLE;
      cen_on     <= 1'b0;
      in_rd_en   <= 1'b0;
      in_rd_addr <= '0;
      SA_fire_in <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fire_cnt   <= '0;
      to_cnt     <= '0;
      dr_cnt     <= '0;
    end else begin
      SA_fire_in <= in_rd_en;
      done       <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state      <= LOAD;
          bank_en_q  <= bank_en;
          cen_on     <= 1'b1;
          in_rd_en   <= 1'b1;
          in_rd_addr <= '0;
          busy       <= 1'b1;
          err        <= 1'b0;
          fire_cnt   <= '0;
          to_cnt     <= '0;
          dr_cnt     <= '0;
        end
        LOAD: begin
          if (in_rd_addr == ADDR_LAST) begin
            state    <= WAIT_OUT;
            in_rd_en <= 1'b0;
          end else begin
            in_rd_addr <= in_rd_addr + SA_ADDR_W'(1);
          end
        end
        WAIT_OUT: begin
          to_cnt <= to_cnt + TO_W'(1);
          if (SA_fire_out) fire_cnt <= fire_cnt + 5'd1;
          // A last fire-out landing on the timeout cycle still counts as success.
          if (SA_fire_out && fire_cnt == FIRE_LAST) begin
            state <= DRAIN;
          end else if (to_cnt == TO_LAST) begin
            state  <= DONE;
            done   <= 1'b1;
            err    <= 1'b1;
            cen_on <= 1'b0;
          end
        end
        DRAIN: begin
          if (dr_cnt == DR_LAST) begin
            state  <= DONE;
            done   <= 1'b1;
            cen_on <= 1'b0;
          end else begin
            dr_cnt <= dr_cnt + DR_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sa_sched.sv
// Bench for sa_sched: two instances (TIMEOUT 255 and 8) share stimulus; a cycle-offset
// job model predicts every output each cycle, plus literal spot checks per scenario.
module tb_sa_sched;
  localparam int TO0 = 255, TO1 = 8, DRAIN = 2;

  logic clk = 1'b0, rst_n, start, abort, fo;
  logic [15:0] bank_en;
  logic        o_en[2], o_fi[2], o_busy[2], o_done[2], o_err[2];
  logic [3:0]  o_addr[2];
  logic [15:0] o_cen[2];
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  sa_sched #(.TIMEOUT(TO0), .DRAIN_CYCLES(DRAIN)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .bank_en(bank_en),
    .in_rd_en(o_en[0]), .in_rd_addr(o_addr[0]), .SA_fire_in(o_fi[0]), .SA_fire_out(fo),
    .CEN(o_cen[0]), .busy(o_busy[0]), .done(o_done[0]), .err(o_err[0]));

  sa_sched #(.TIMEOUT(TO1), .DRAIN_CYCLES(DRAIN)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .bank_en(bank_en),
    .in_rd_en(o_en[1]), .in_rd_addr(o_addr[1]), .SA_fire_in(o_fi[1]), .SA_fire_out(fo),
    .CEN(o_cen[1]), .busy(o_busy[1]), .done(o_done[1]), .err(o_err[1]));

  // inputs as the DUT saw them at the latest rising edge
  logic s_rst = 1'b0, s_start = 1'b0, s_abort = 1'b0, s_fo = 1'b0;
  logic [15:0] s_bank = '0;
  always @(posedge clk) begin
    s_rst <= rst_n; s_start <= start; s_abort <= abort; s_fo <= fo; s_bank <= bank_en;
  end

  // Model: a job is described by its start edge t; outputs follow from n = edge - t,
  // and the done edge is fixed once the 16th fire-out or the timeout is seen.
  int          m_t[2], m_dedge[2], m_fires[2], m_waits[2];
  logic        m_act[2], m_err[2], prev_idle[2];
  logic [15:0] m_bank[2];
  logic [3:0]  m_addr[2];

  initial begin
    int e, n, to;
    logic x_en, x_fi, x_busy, x_done;
    logic [15:0] x_cen;
    logic [24:0] xv, av;
    e = 0;
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_err[i] = 0; m_addr[i] = 0; m_bank[i] = 0; prev_idle[i] = 1;
      m_t[i] = 0; m_dedge[i] = -1; m_fires[i] = 0; m_waits[i] = 0;
    end
    forever begin
      @(negedge clk);
      e++;
      for (int i = 0; i < 2; i++) begin
        to = (i == 0) ? TO0 : TO1;
        if (!rst_n) begin
          m_act[i] = 0; m_err[i] = 0; m_addr[i] = 0; m_bank[i] = 0;
        end else if (s_rst) begin
          if (s_abort) begin
            m_act[i] = 0; m_addr[i] = 0;
          end else if (prev_idle[i] && s_start) begin
            m_act[i] = 1; m_t[i] = e; m_dedge[i] = -1; m_fires[i] = 0; m_waits[i] = 0;
            m_bank[i] = s_bank; m_err[i] = 0;
          end else if (m_act[i] && m_dedge[i] < 0 && e - m_t[i] >= 17) begin
            m_waits[i]++;
            if (s_fo) m_fires[i]++;
            if (m_fires[i] == 16) m_dedge[i] = e + DRAIN;
            else if (m_waits[i] == to) begin m_dedge[i] = e; m_err[i] = 1; end
          end
          if (m_act[i] && m_dedge[i] >= 0 && e > m_dedge[i]) m_act[i] = 0;
        end
        n = e - m_t[i];
        x_en = m_act[i] && n <= 15;
        if (x_en) m_addr[i] = 4'(n);
        x_fi   = m_act[i] && n >= 1 && n <= 16;
        x_done = m_act[i] && e == m_dedge[i];
        x_busy = m_act[i];
        x_cen  = (m_act[i] && !x_done) ? ~m_bank[i] : 16'hFFFF;
        prev_idle[i] = !x_busy;
        xv = {x_en, m_addr[i], x_fi, x_cen, x_busy, x_done, m_err[i]};
        av = {o_en[i], o_addr[i], o_fi[i], o_cen[i], o_busy[i], o_done[i], o_err[i]};
        total++;
        if (av !== xv) begin
          bad++;
          $display("FAIL model_cmp dut%0d edge=%0d got{en,addr,fi,cen,busy,done,err}=%h want=%h",
                   i, e, av, xv);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((o_busy[0] || o_busy[1]) && n < 400) begin cyc(); n++; end
    chk("idle_wait", {o_busy[0], o_busy[1]}, 0);
  endtask

  task automatic go(input logic [15:0] bank);
    bank_en = bank; start = 1; cyc(); start = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; start = 0; abort = 0; bank_en = '0; fo = 0;
    cyc(); cyc();
    chk("rst_cen", o_cen[0], 16'hFFFF);
    chk("rst_busy_en_fi", {o_busy[0], o_en[0], o_fi[0], o_done[0], o_err[0]}, 0);
    rst_n = 1; cyc(); cyc();

    // nominal job
    go(16'hFFFF);
    for (int k = 1; k <= 40; k++) begin
      fo = (k >= 20 && k <= 35);
      case (k)
        1:  begin chk("nom_t1_en_addr", {o_en[0], o_addr[0]}, 5'h10); chk("nom_t1_cen", o_cen[0], 0);
                  chk("nom_t1_fi", o_fi[0], 0); end
        2:  chk("nom_t2_fi", o_fi[0], 1);
        16: chk("nom_t16_en_addr", {o_en[0], o_addr[0]}, 5'h1F);
        17: chk("nom_t17_en_fi", {o_en[0], o_fi[0]}, 2'b01);
        18: chk("nom_t18_fi", o_fi[0], 0);
        25: chk("nom_to8_done_err", {o_done[1], o_err[1]}, 2'b11);
        37: chk("nom_t37_cen_done", {o_cen[0], o_done[0]}, 17'h0);
        38: begin chk("nom_t38_done_err", {o_done[0], o_err[0]}, 2'b10);
                  chk("nom_t38_cen", o_cen[0], 16'hFFFF); end
        39: chk("nom_t39_busy_done", {o_busy[0], o_done[0]}, 0);
        default: ;
      endcase
      cyc();
    end
    fo = 0; wait_idle();

    // bank mask
    go(16'h00F0);
    for (int k = 1; k <= 40; k++) begin
      fo = (k >= 20 && k <= 35);
      case (k)
        1:  chk("mask_err1_cleared", o_err[1], 0);
        5:  chk("mask_cen", o_cen[0], 16'hFF0F);
        38: chk("mask_done_cen", {o_done[0], o_cen[0]}, 17'h1FFFF);
        39: chk("mask_idle_cen", o_cen[0], 16'hFFFF);
        default: ;
      endcase
      cyc();
    end
    fo = 0; wait_idle();

    // timeout on the TIMEOUT=8 instance; zero bank mask; abort+start in IDLE
    go(16'h0000);
    for (int k = 1; k <= 30; k++) begin
      start = (k == 27); abort = (k == 27);
      case (k)
        5:  chk("zero_bank_cen_busy", {o_cen[0], o_busy[0]}, 17'h1FFFF);
        24: chk("to_t24_done", o_done[1], 0);
        25: chk("to_t25_done_err", {o_done[1], o_err[1]}, 2'b11);
        28: begin chk("abort_idle_busy", {o_busy[0], o_busy[1]}, 0);
                  chk("abort_keeps_err", o_err[1], 1); end
        30: chk("to_err_held", {o_err[1], o_busy[1]}, 2'b10);
        default: ;
      endcase
      cyc();
    end
    start = 0; abort = 0; wait_idle();

    // gapped fire-out, start ignored during WAIT_OUT
    go(16'hFFFF);
    for (int k = 1; k <= 56; k++) begin
      fo = (k >= 20 && k <= 50 && (k % 2 == 0));
      start = (k == 30);
      case (k)
        31: chk("gap_start_ignored", {o_en[0], o_en[1]}, 2'b01);
        50: chk("gap_t50_busy_done", {o_busy[0], o_done[0]}, 2'b10);
        52: chk("gap_t52_done", o_done[0], 0);
        53: chk("gap_t53_done_err", {o_done[0], o_err[0]}, 2'b10);
        default: ;
      endcase
      cyc();
    end
    fo = 0; start = 0; wait_idle();

    // abort in LOAD, restart
    go(16'hFFFF);
    for (int k = 1; k <= 48; k++) begin
      abort = (k == 5); start = (k == 7);
      fo = (k >= 27 && k <= 42);
      case (k)
        5:  chk("ab_t5_en", o_en[0], 1);
        6:  begin chk("ab_t6_cen", o_cen[0], 16'hFFFF);
                  chk("ab_t6_state", {o_en[0], o_fi[0], o_busy[0], o_done[0]}, 0); end
        8:  chk("ab_restart_en_addr", {o_en[0], o_addr[0]}, 5'h10);
        44: chk("ab_t44_done", o_done[0], 0);
        45: chk("ab_t45_done_err", {o_done[0], o_err[0]}, 2'b10);
        default: ;
      endcase
      cyc();
    end
    abort = 0; start = 0; fo = 0; wait_idle();

    // asynchronous reset mid-WAIT_OUT
    go(16'hFFFF);
    for (int k = 1; k <= 30; k++) begin
      if (k == 29) chk("rst_pre_busy_err", {o_busy[0], o_err[1]}, 2'b11);
      if (k == 30) begin
        #2 rst_n = 0; #1;
        chk("arst_cen", o_cen[0], 16'hFFFF);
        chk("arst_outs", {o_en[0], o_addr[0], o_fi[0], o_busy[0], o_done[0], o_err[0]}, 0);
        chk("arst_err1", o_err[1], 0);
      end else begin
        cyc();
      end
    end
    cyc(); rst_n = 1;
    cyc(); cyc();
    go(16'hFFFF);
    chk("post_rst_start", {o_en[0], o_addr[0], o_busy[0]}, 6'h21);
    cyc(); cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
